// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
//   Bundles the serial input pin and the byte-level result of the UART receiver.
//   Signals:
//     RxD            serial line into the receiver (idle high, asynchronous)
//     data           last correctly framed byte
//     data_valid     one-cycle strobe, data updated on the same edge
//     framing_error  one-cycle strobe, stop bit sampled low
//     busy           receiver is inside a frame
//   Modports:
//     slave   the receiver itself (consumes RxD, produces the byte results)
//     master  the environment (drives RxD, consumes the byte results)
// -----------------------------------------------------------------------------
interface uart_receiver_if;
  logic       RxD;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  modport slave  (input  RxD, output data, output data_valid, output framing_error, output busy);
  modport master (output RxD, input  data, input  data_valid, input  framing_error, input  busy);
endinterface

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver (LSB first, idle-high line). RxD is brought into the clk
//   domain by a two-flop synchroniser, a falling edge starts a frame, the start
//   bit is re-checked at mid-bit and every following bit is sampled at mid-bit.
//   A correctly framed byte is presented on data with a one-cycle data_valid;
//   a low stop bit produces a one-cycle framing_error and leaves data unchanged.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low
//     rx     uart_receiver_if.slave (RxD in; data, data_valid, framing_error, busy out)
//   Parameter:
//     CLKS_PER_BIT  clk cycles per bit (>= 4), matches the transmitter divider
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 28
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          sync1_q;
  logic          rx_s_q;
  logic          rx_prev_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;
  logic          fall;
  logic          tick;

  // Edge detect needs the previous synchronised level to be high, so a line
  // that simply stays low (break, or after a framing error) never restarts.
  assign fall = rx_prev_q & ~rx_s_q;

  // The start bit is re-checked half a bit in; all other bits one bit apart.
  assign tick = (state_q == START) ? (cnt_q == HALF_TERM) : (cnt_q == FULL_TERM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Counter parked at zero so every entry into START begins cleared.
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack to catch a
        // start bit that follows the stop bit with no idle gap.
        if (tick) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d = shift_q;
            vld_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Synchroniser, edge history and control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= 8'h00;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx.RxD;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
    end
  end

  // Assembly register; its content only matters after eight DATA samples.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx.data          = data_q;
  assign rx.data_valid    = vld_q;
  assign rx.framing_error = ferr_q;
  assign rx.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int CPB = 28;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  uart_receiver_if u ();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level expectation: one result pulse per frame whose start bit
  // reached the line, 269..270 cycles after the start-bit pin edge.
  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         pin;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_data = 8'h00;

  int vectors     = 0;
  int miscompares = 0;
  int nvld        = 0;
  int nferr       = 0;
  int last_lat    = 0;

  bit b2b_arm   = 0;
  int b2b_stage = 0;
  int b2b_low   = 0;
  int b2b_runs  = 0;
  bit prev_busy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Per-cycle comparison against the frame-level model
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      exp_q.delete();
      exp_data = 8'h00;
    end else begin
      ev_t e;
      if (u.data_valid || u.framing_error) begin
        chk("pulse_exclusive", {31'd0, u.data_valid & u.framing_error}, 32'd0);
        if (u.data_valid) nvld++;
        if (u.framing_error) nferr++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          last_lat = cyc - e.pin;
          chk("pulse_kind", {31'd0, u.framing_error}, {31'd0, e.is_err});
          chk("pulse_latency_ok", {31'd0, (last_lat == 269 || last_lat == 270)}, 32'd1);
          if (!e.is_err) exp_data = e.b;
        end
        if (u.data_valid && b2b_arm) begin
          if (b2b_stage == 0) b2b_stage = 1;
          else if (b2b_stage == 1) b2b_stage = 2;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].pin + 270) begin
        chk("missing_pulse", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      if (b2b_stage == 1 && !u.busy) begin
        b2b_low++;
        if (prev_busy) b2b_runs++;
      end
      chk("data", {24'd0, u.data}, {24'd0, exp_data});
    end
    prev_busy = u.busy;
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    u.RxD = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    u.RxD    = 1'b0;
    e.pin    = cyc;
    e.is_err = !stop;
    e.b      = b;
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1;
      u.RxD = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1;
    u.RxD = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, f0;
    reset = 1'b0;
    u.RxD = 1'b1;
    #2;
    chk("reset_data",  {24'd0, u.data}, 32'h00);
    chk("reset_valid", {31'd0, u.data_valid}, 32'd0);
    chk("reset_ferr",  {31'd0, u.framing_error}, 32'd0);
    chk("reset_busy",  {31'd0, u.busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(10);

    // 1: single byte
    v0 = nvld; f0 = nferr;
    send_frame(8'hA5, 1'b1);
    idle(2 * CPB);
    chk("t1_valid_count", nvld - v0, 1);
    chk("t1_ferr_count", nferr - f0, 0);
    chk("t1_data", {24'd0, u.data}, 32'hA5);
    chk("t1_latency", {31'd0, (last_lat == 269 || last_lat == 270)}, 32'd1);

    // 2: back-to-back, zero idle gap
    v0 = nvld; f0 = nferr;
    b2b_arm = 1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * CPB);
    b2b_arm = 0;
    chk("t2_valid_count", nvld - v0, 2);
    chk("t2_ferr_count", nferr - f0, 0);
    chk("t2_data", {24'd0, u.data}, 32'hFF);
    chk("t2_second_caught", b2b_stage, 2);
    chk("t2_idle_runs", b2b_runs, 1);
    chk("t2_idle_short", {31'd0, (b2b_low <= CPB / 2 + 3)}, 32'd1);

    // 3: short glitch rejected at start-bit re-check
    v0 = nvld; f0 = nferr;
    u.RxD = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_busy_in_start", {31'd0, u.busy}, 32'd1);
    idle(2 * CPB);
    chk("t3_busy_after", {31'd0, u.busy}, 32'd0);
    chk("t3_valid_count", nvld - v0, 0);
    chk("t3_ferr_count", nferr - f0, 0);

    // 4: good byte, then a frame with a low stop bit
    v0 = nvld; f0 = nferr;
    send_frame(8'h3C, 1'b1);
    idle(CPB);
    send_frame(8'h81, 1'b0);
    idle(2 * CPB);
    chk("t4_valid_count", nvld - v0, 1);
    chk("t4_ferr_count", nferr - f0, 1);
    chk("t4_data", {24'd0, u.data}, 32'h3C);

    // 5: break, then a normal byte
    v0 = nvld; f0 = nferr;
    begin
      ev_t e;
      u.RxD    = 1'b0;
      e.pin    = cyc;
      e.is_err = 1'b1;
      e.b      = 8'h00;
      exp_q.push_back(e);
    end
    repeat (20 * CPB) @(posedge clk);
    #1;
    chk("t5_busy_in_break", {31'd0, u.busy}, 32'd0);
    chk("t5_ferr_in_break", nferr - f0, 1);
    idle(3 * CPB);
    send_frame(8'h5A, 1'b1);
    idle(2 * CPB);
    chk("t5_valid_count", nvld - v0, 1);
    chk("t5_ferr_count", nferr - f0, 1);
    chk("t5_data", {24'd0, u.data}, 32'h5A);

    // 6: reset during bit 4 of a frame, then a normal byte
    v0 = nvld; f0 = nferr;
    begin
      logic [7:0] ab;
      ab = 8'hC3;
      u.RxD = 1'b0;
      for (int i = 0; i < 5; i++) begin
        repeat (CPB) @(posedge clk);
        #1;
        u.RxD = ab[i];
      end
    end
    repeat (10) @(posedge clk);
    #1;
    chk("t6_busy_before", {31'd0, u.busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_data",  {24'd0, u.data}, 32'h00);
    chk("t6_rst_valid", {31'd0, u.data_valid}, 32'd0);
    chk("t6_rst_ferr",  {31'd0, u.framing_error}, 32'd0);
    chk("t6_rst_busy",  {31'd0, u.busy}, 32'd0);
    u.RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2 * CPB);
    chk("t6_aborted_valid", nvld - v0, 0);
    chk("t6_aborted_ferr", nferr - f0, 0);
    send_frame(8'h42, 1'b1);
    idle(2 * CPB);
    chk("t6_valid_count", nvld - v0, 1);
    chk("t6_data", {24'd0, u.data}, 32'h42);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
